// File: rtl/prco_wb_queue.sv
// prco_wb_queue: PRCO write-back queue with a pending-write scoreboard.
// Build with PRCO_WB_BYPASS_EN to let an empty queue forward straight to the write port.
module prco_wb_queue #(
   parameter int DEPTH = 4
) (
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic        i_en,
   input  logic        i_alu_valid,
   input  logic [2:0]  i_alu_seld,
   input  logic [15:0] i_alu_dat,
   input  logic        i_ram_valid,
   input  logic [2:0]  i_ram_seld,
   input  logic [15:0] i_ram_dat,
   output logic        q_alu_rdy,
   output logic        q_ram_rdy,
   input  logic [2:0]  i_sela,
   input  logic [2:0]  i_selb,
   output logic        q_we,
   output logic [2:0]  q_seld,
   output logic [15:0] q_datd,
   output logic [7:0]  q_pending,
   output logic        q_stall,
   output logic        q_idle
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [2:0]    mem_seld [DEPTH];
   logic [15:0]   mem_dat  [DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr, wr_ptr1;
   logic [CW-1:0] count, free, ram_need;
   logic          alu_acc, ram_acc, pop;
   logic          push0, push1, byp;
   logic [2:0]    push0_seld, push1_seld, byp_seld;
   logic [15:0]   push0_dat, push1_dat, byp_dat;
   logic [1:0]    n_push;
   logic [AW-1:0] offs;

   // Handshake: an offer transfers on a cycle where its valid and rdy are both high.
   // rdy depends only on i_en, occupancy and i_alu_valid; a same-cycle retire frees nothing.
   assign free      = DEPTH_C - count;
   assign ram_need  = i_alu_valid ? CW'(2) : CW'(1);
   assign q_alu_rdy = i_en & (free >= CW'(1));
   assign q_ram_rdy = i_en & (free >= ram_need);
   assign alu_acc   = i_alu_valid & q_alu_rdy;
   assign ram_acc   = i_ram_valid & q_ram_rdy;
   assign pop       = i_en & (count != '0);
   assign wr_ptr1   = wr_ptr + AW'(1);

   always_comb begin
      byp        = 1'b0;
      byp_seld   = i_alu_seld;
      byp_dat    = i_alu_dat;
      push0      = alu_acc;
      push0_seld = i_alu_seld;
      push0_dat  = i_alu_dat;
      push1      = 1'b0;
      push1_seld = i_ram_seld;
      push1_dat  = i_ram_dat;
      if (!alu_acc) begin
         push0      = ram_acc;
         push0_seld = i_ram_seld;
         push0_dat  = i_ram_dat;
      end else begin
         push1 = ram_acc;
      end
`ifdef PRCO_WB_BYPASS_EN
      // Empty and not popping: the oldest accepted entry goes straight to the write port.
      if (count == '0 && push0) begin
         byp        = 1'b1;
         byp_seld   = push0_seld;
         byp_dat    = push0_dat;
         push0      = push1;
         push0_seld = push1_seld;
         push0_dat  = push1_dat;
         push1      = 1'b0;
      end
`endif
      n_push = {1'b0, push0} + {1'b0, push1};
   end

   always_ff @(posedge i_clk) begin
      if (push0) begin
         mem_seld[wr_ptr] <= push0_seld;
         mem_dat[wr_ptr]  <= push0_dat;
      end
      if (push1) begin
         mem_seld[wr_ptr1] <= push1_seld;
         mem_dat[wr_ptr1]  <= push1_dat;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         q_we   <= 1'b0;
         q_seld <= 3'd0;
         q_datd <= 16'h0000;
      end else begin
         wr_ptr <= wr_ptr + AW'(n_push);
         rd_ptr <= rd_ptr + AW'(pop);
         count  <= count + CW'(n_push) - CW'(pop);
         if (pop) begin
            q_we   <= 1'b1;
            q_seld <= mem_seld[rd_ptr];
            q_datd <= mem_dat[rd_ptr];
         end else if (byp) begin
            q_we   <= 1'b1;
            q_seld <= byp_seld;
            q_datd <= byp_dat;
         end else begin
            q_we <= 1'b0;
         end
      end
   end

   // An entry is live when its distance from the read pointer is below the count.
   always_comb begin
      q_pending = 8'h00;
      offs      = '0;
      for (int i = 0; i < DEPTH; i++) begin
         offs = AW'(i) - rd_ptr;
         if ({1'b0, offs} < count) q_pending[mem_seld[i]] = 1'b1;
      end
      if (q_we) q_pending[q_seld] = 1'b1;
   end

   assign q_stall = q_pending[i_sela] | q_pending[i_selb];
   assign q_idle  = (count == '0) & ~q_we;

endmodule

// File: tb/tb_prco_wb_queue.sv
// tb_prco_wb_queue: checks prco_wb_queue against a queue-based model of the write-back rules.
// Honours PRCO_WB_BYPASS_EN so the same bench covers both builds.
module tb_prco_wb_queue;
   localparam int DEPTH = 4;
`ifdef PRCO_WB_BYPASS_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 2;
`endif

   logic        i_clk = 1'b0, i_reset_n = 1'b1, i_en = 1'b0;
   logic        i_alu_valid = 1'b0, i_ram_valid = 1'b0;
   logic [2:0]  i_alu_seld = 3'd0, i_ram_seld = 3'd0, i_sela = 3'd0, i_selb = 3'd0;
   logic [15:0] i_alu_dat = 16'h0, i_ram_dat = 16'h0;
   logic        q_alu_rdy, q_ram_rdy, q_we, q_stall, q_idle;
   logic [2:0]  q_seld;
   logic [15:0] q_datd;
   logic [7:0]  q_pending;

   int checks = 0;
   int failures = 0;

   // Model: FIFO contents as a queue plus the registered write-port state.
   logic [18:0] m_q[$];
   logic        m_we = 1'b0;
   logic [2:0]  m_seld = 3'd0;
   logic [15:0] m_dat = 16'h0;
   logic [18:0] exp_q[$];

   prco_wb_queue #(.DEPTH(DEPTH)) dut (
      .i_clk(i_clk), .i_reset_n(i_reset_n), .i_en(i_en),
      .i_alu_valid(i_alu_valid), .i_alu_seld(i_alu_seld), .i_alu_dat(i_alu_dat),
      .i_ram_valid(i_ram_valid), .i_ram_seld(i_ram_seld), .i_ram_dat(i_ram_dat),
      .q_alu_rdy(q_alu_rdy), .q_ram_rdy(q_ram_rdy), .i_sela(i_sela), .i_selb(i_selb),
      .q_we(q_we), .q_seld(q_seld), .q_datd(q_datd),
      .q_pending(q_pending), .q_stall(q_stall), .q_idle(q_idle)
   );

   // ---------------- clock / reset ----------------
   always #5 i_clk = ~i_clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- model ----------------
   function automatic bit m_alu_rdy();
      return i_en && (DEPTH - m_q.size() >= 1);
   endfunction

   function automatic bit m_ram_rdy();
      return i_en && (DEPTH - m_q.size() >= (i_alu_valid ? 2 : 1));
   endfunction

   function automatic logic [7:0] m_pending();
      logic [7:0] p;
      p = 8'h00;
      foreach (m_q[i]) p[m_q[i][18:16]] = 1'b1;
      if (m_we) p[m_seld] = 1'b1;
      return p;
   endfunction

   task automatic model_clear();
      m_q.delete();
      exp_q.delete();
      m_we = 1'b0;
      m_seld = 3'd0;
      m_dat = 16'h0;
   endtask

   // ---------------- driver ----------------
   task automatic drive(input logic en, input logic av, input logic [2:0] as, input logic [15:0] ad,
                        input logic rv, input logic [2:0] rs, input logic [15:0] rdat);
      i_en = en;
      i_alu_valid = av; i_alu_seld = as; i_alu_dat = ad;
      i_ram_valid = rv; i_ram_seld = rs; i_ram_dat = rdat;
   endtask

   // One rising edge: advance the model alongside the DUT, return 1 time unit after the edge.
   task automatic step();
      bit a_acc, r_acc;
      int n;
      n = m_q.size();
      a_acc = i_alu_valid && m_alu_rdy();
      r_acc = i_ram_valid && m_ram_rdy();
      @(posedge i_clk);
      if (a_acc) exp_q.push_back({i_alu_seld, i_alu_dat});
      if (r_acc) exp_q.push_back({i_ram_seld, i_ram_dat});
      m_we = 1'b0;
      if (i_en && n > 0) begin
         {m_seld, m_dat} = m_q.pop_front();
         m_we = 1'b1;
      end
`ifdef PRCO_WB_BYPASS_EN
      else if (a_acc) begin
         m_we = 1'b1; m_seld = i_alu_seld; m_dat = i_alu_dat; a_acc = 1'b0;
      end else if (r_acc) begin
         m_we = 1'b1; m_seld = i_ram_seld; m_dat = i_ram_dat; r_acc = 1'b0;
      end
`endif
      if (a_acc) m_q.push_back({i_alu_seld, i_alu_dat});
      if (r_acc) m_q.push_back({i_ram_seld, i_ram_dat});
      #1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      drive(1, 0, 0, 0, 0, 0, 0);
      i_sela = 3'd3; i_selb = 3'd5;
      #1 i_reset_n = 1'b0;
      model_clear();
      #2;
      checks++; if ({q_we, q_seld, q_datd} !== 20'h0) begin failures++;
         $display("FAIL reset_wport got=%h exp=00000", {q_we, q_seld, q_datd}); end
      checks++; if ({q_pending, q_stall, q_idle} !== {8'h00, 1'b0, 1'b1}) begin failures++;
         $display("FAIL reset_status got pend=%h stall=%b idle=%b", q_pending, q_stall, q_idle); end
      checks++; if ({q_alu_rdy, q_ram_rdy} !== 2'b11) begin failures++;
         $display("FAIL reset_rdy_en1 got=%b exp=11", {q_alu_rdy, q_ram_rdy}); end
      i_en = 1'b0; #1;
      checks++; if ({q_alu_rdy, q_ram_rdy} !== 2'b00) begin failures++;
         $display("FAIL reset_rdy_en0 got=%b exp=00", {q_alu_rdy, q_ram_rdy}); end
      @(posedge i_clk); #1;
      i_reset_n = 1'b1; i_en = 1'b1;
   endtask

   task automatic test_single();
      drive(1, 1, 3'd3, 16'hBEEF, 0, 0, 0);
      for (int k = 1; k <= 4; k++) begin
         step();
         drive(1, 0, 0, 0, 0, 0, 0);
         checks++; if (q_we !== 1'(k == LAT)) begin failures++;
            $display("FAIL single_we edge=%0d got=%b exp=%b", k, q_we, (k == LAT)); end
         if (k == LAT) begin
            checks++; if ({q_seld, q_datd} !== {3'd3, 16'hBEEF}) begin failures++;
               $display("FAIL single_data got=%0d/%h exp=3/beef", q_seld, q_datd); end
         end
         checks++; if (q_pending !== ((k <= LAT) ? 8'h08 : 8'h00)) begin failures++;
            $display("FAIL single_pending edge=%0d got=%h", k, q_pending); end
         checks++; if (q_idle !== 1'(k > LAT)) begin failures++;
            $display("FAIL single_idle edge=%0d got=%b exp=%b", k, q_idle, (k > LAT)); end
      end
   endtask

   task automatic test_simultaneous();
      int n_wr = 0;
      int t_first = -1;
      drive(1, 1, 3'd1, 16'h0011, 1, 3'd2, 16'h0022);
      #1;
      checks++; if ({q_alu_rdy, q_ram_rdy} !== 2'b11) begin failures++;
         $display("FAIL simul_rdy got=%b exp=11", {q_alu_rdy, q_ram_rdy}); end
      for (int k = 1; k <= 5; k++) begin
         step();
         drive(1, 0, 0, 0, 0, 0, 0);
         if (q_we) begin
            checks++; if ({q_seld, q_datd} !== ((n_wr == 0) ? {3'd1, 16'h0011} : {3'd2, 16'h0022})) begin
               failures++; $display("FAIL simul_order write=%0d got=%0d/%h", n_wr, q_seld, q_datd); end
            if (n_wr == 1) begin
               checks++; if (k !== t_first + 1) begin failures++;
                  $display("FAIL simul_consecutive got edge=%0d exp=%0d", k, t_first + 1); end
            end
            if (n_wr == 0) t_first = k;
            n_wr++;
         end
      end
      checks++; if (n_wr !== 2) begin failures++; $display("FAIL simul_count got=%0d exp=2", n_wr); end
   endtask

   task automatic test_fill();
      logic [18:0] got;
      exp_q.delete();
      for (int k = 0; k < 12; k++) begin
         if (k < 4) drive(1, 1, 3'($urandom_range(0, 7)), 16'($urandom), 1, 3'($urandom_range(0, 7)), 16'($urandom));
         else drive(1, 0, 0, 0, 0, 0, 0);
         #1;
         checks++; if ({q_alu_rdy, q_ram_rdy} !== {m_alu_rdy(), m_ram_rdy()}) begin failures++;
            $display("FAIL fill_rdy cyc=%0d got=%b exp=%b%b", k, {q_alu_rdy, q_ram_rdy}, m_alu_rdy(), m_ram_rdy()); end
         step();
         checks++; if ({q_we, q_seld, q_datd} !== {m_we, m_seld, m_dat}) begin failures++;
            $display("FAIL fill_wport cyc=%0d got=%h exp=%h", k, {q_we, q_seld, q_datd}, {m_we, m_seld, m_dat}); end
         if (q_we) begin
            got = {q_seld, q_datd};
            checks++; if (exp_q.size() == 0 || exp_q[0] !== got) begin failures++;
               $display("FAIL fill_scoreboard got=%h exp=%h", got, (exp_q.size() != 0) ? exp_q[0] : 19'h0); end
            if (exp_q.size() != 0) void'(exp_q.pop_front());
         end
      end
      checks++; if (exp_q.size() !== 0 || q_idle !== 1'b1) begin failures++;
         $display("FAIL fill_drained got left=%0d idle=%b exp left=0 idle=1", exp_q.size(), q_idle); end
   endtask

   task automatic test_duplicate();
      logic [15:0] last = 16'h0;
      int n5 = 0;
      i_sela = 3'd5; i_selb = 3'd0;
      for (int k = 0; k < 7; k++) begin
         if (k == 0) drive(1, 1, 3'd5, 16'h0001, 0, 0, 0);
         else if (k == 1) drive(1, 1, 3'd5, 16'h0002, 0, 0, 0);
         else drive(1, 0, 0, 0, 0, 0, 0);
         step();
         if (q_we && q_seld == 3'd5) begin n5++; last = q_datd; end
         checks++; if (q_pending[5] !== 1'(n5 < 2 || (q_we && n5 == 2))) begin failures++;
            $display("FAIL dup_pending5 cyc=%0d got=%b writes=%0d", k, q_pending[5], n5); end
         checks++; if (q_stall !== (m_pending()[5] | m_pending()[0])) begin failures++;
            $display("FAIL dup_stall cyc=%0d got=%b exp=%b", k, q_stall, m_pending()[5]); end
      end
      checks++; if (n5 !== 2 || last !== 16'h0002) begin failures++;
         $display("FAIL dup_final got writes=%0d last=%h exp writes=2 last=0002", n5, last); end
   endtask

   task automatic test_reset_mid_drain();
      drive(1, 1, 3'd1, 16'h1111, 1, 3'd2, 16'h2222);
      step();
      drive(1, 1, 3'd3, 16'h3333, 0, 0, 0);
      step();
      drive(1, 0, 0, 0, 0, 0, 0);
      checks++; if (q_we !== 1'b1) begin failures++; $display("FAIL rstmid_pre_we got=%b exp=1", q_we); end
      #2 i_reset_n = 1'b0;
      model_clear();
      #1;
      checks++; if (q_we !== 1'b0) begin failures++; $display("FAIL rstmid_we got=%b exp=0", q_we); end
      checks++; if ({q_pending, q_idle} !== {8'h00, 1'b1}) begin failures++;
         $display("FAIL rstmid_status got pend=%h idle=%b exp 00/1", q_pending, q_idle); end
      @(posedge i_clk); #1;
      i_reset_n = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         step();
         checks++; if (q_we !== 1'b0 || q_pending !== 8'h00) begin failures++;
            $display("FAIL rstmid_stale cyc=%0d got we=%b pend=%h", k, q_we, q_pending); end
      end
   endtask

   task automatic test_enable_hold();
      int n_wr = 0;
      drive(1, 1, 3'd4, 16'h4444, 1, 3'd6, 16'h6666);
      for (int k = 0; k < 9; k++) begin
         if (k >= 1 && k <= 3) drive(0, 1, 3'd7, 16'h7777, 1, 3'd7, 16'h7777);
         else if (k > 3) drive(1, 0, 0, 0, 0, 0, 0);
         if (k >= 1 && k <= 3) begin
            #1;
            checks++; if ({q_alu_rdy, q_ram_rdy} !== 2'b00) begin failures++;
               $display("FAIL hold_rdy cyc=%0d got=%b exp=00", k, {q_alu_rdy, q_ram_rdy}); end
         end
         step();
         if (k >= 1 && k <= 3) begin
            checks++; if (q_we !== 1'b0) begin failures++; $display("FAIL hold_we cyc=%0d got=%b exp=0", k, q_we); end
         end
         if (q_we) begin
            checks++; if ({q_seld, q_datd} !== ((n_wr == 0) ? {3'd4, 16'h4444} : {3'd6, 16'h6666})) begin
               failures++; $display("FAIL hold_order write=%0d got=%0d/%h", n_wr, q_seld, q_datd); end
            n_wr++;
         end
      end
      checks++; if (n_wr !== 2) begin failures++; $display("FAIL hold_count got=%0d exp=2", n_wr); end
   endtask

   task automatic test_random();
      logic [18:0] got;
      logic [7:0]  p;
      exp_q.delete();
      for (int c = 0; c < 420; c++) begin
         if (c < 400)
            drive(1'($urandom_range(0, 7) != 0),
                  1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), 16'($urandom),
                  1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), 16'($urandom));
         else drive(1, 0, 0, 0, 0, 0, 0);
         i_sela = 3'($urandom_range(0, 7));
         i_selb = 3'($urandom_range(0, 7));
         #1;
         checks++; if ({q_alu_rdy, q_ram_rdy} !== {m_alu_rdy(), m_ram_rdy()}) begin failures++;
            $display("FAIL rand_rdy cyc=%0d got=%b exp=%b%b", c, {q_alu_rdy, q_ram_rdy}, m_alu_rdy(), m_ram_rdy()); end
         step();
         p = m_pending();
         checks++; if ({q_we, q_seld, q_datd} !== {m_we, m_seld, m_dat}) begin failures++;
            $display("FAIL rand_wport cyc=%0d got=%h exp=%h", c, {q_we, q_seld, q_datd}, {m_we, m_seld, m_dat}); end
         checks++; if (q_pending !== p) begin failures++;
            $display("FAIL rand_pending cyc=%0d got=%h exp=%h", c, q_pending, p); end
         checks++; if (q_stall !== (p[i_sela] | p[i_selb])) begin failures++;
            $display("FAIL rand_stall cyc=%0d got=%b exp=%b", c, q_stall, p[i_sela] | p[i_selb]); end
         checks++; if (q_idle !== 1'(m_q.size() == 0 && !m_we)) begin failures++;
            $display("FAIL rand_idle cyc=%0d got=%b", c, q_idle); end
         if (q_we) begin
            got = {q_seld, q_datd};
            checks++; if (exp_q.size() == 0 || exp_q[0] !== got) begin failures++;
               $display("FAIL rand_scoreboard got=%h exp=%h", got, (exp_q.size() != 0) ? exp_q[0] : 19'h0); end
            if (exp_q.size() != 0) void'(exp_q.pop_front());
         end
      end
      checks++; if (exp_q.size() !== 0) begin failures++;
         $display("FAIL rand_leftover got=%0d exp=0", exp_q.size()); end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_single();
      test_simultaneous();
      test_fill();
      test_duplicate();
      test_reset_mid_drain();
      test_enable_hold();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
